// File: rtl/mr_ring.sv
// mr_ring: synchronous model of a one-hot multi-rail ring with TH22 stages, wave
// counting, idle watchdog and an optional period meter (MR_RING_PERIOD_EN).
module mr_ring #(
  parameter int RAILS  = 3,
  parameter int STAGES = 4,
  parameter int ROT    = 1,
  parameter int DSTAGE = STAGES - 1,
  parameter int DINIT  = 0,
  parameter int CW     = 16,
  parameter int WDOG   = 16
) (
  input  logic                    clk,
  input  logic                    init_n,
  input  logic                    en,
  input  logic [STAGES-1:0]       hold,
  output logic [STAGES*RAILS-1:0] ring,
  output logic [STAGES-1:0]       comp,
  output logic [CW-1:0]           wave_cnt,
  output logic [RAILS-1:0]        data_val,
  output logic [CW-1:0]           period,
  output logic                    stuck
);

  localparam int            NB        = STAGES * RAILS;
  localparam logic [NB-1:0] RING_INIT = NB'(1) << (DSTAGE * RAILS + DINIT);
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic [STAGES-1:0][RAILS-1:0] ring_q;
  logic [STAGES-1:0][RAILS-1:0] ring_nx;
  logic [CW-1:0]                wd_cnt;
  logic                         arrival;
  logic                         idle;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int NXT = (s + 1) % STAGES;
    logic [RAILS-1:0] stg_in;
    logic             stg_en;

    if (s == 0) begin : g_head
      // The wrap-around link rotates the rails so each lap carries a new code.
      for (genvar r = 0; r < RAILS; r++) begin : g_rot
        assign stg_in[r] = ring_q[STAGES-1][(r + ROT) % RAILS];
      end
    end else begin : g_body
      assign stg_in = ring_q[s-1];
    end

    assign stg_en     = ~comp[NXT];
    assign comp[s]    = |ring_q[s];
    // Majority of (input, enable, current) is exactly the TH22 set/clear/keep rule.
    assign ring_nx[s] = hold[s] ? ring_q[s]
                      : (stg_in & {RAILS{stg_en}}) | (ring_q[s] & (stg_in | {RAILS{stg_en}}));
  end

  assign ring    = ring_q;
  assign arrival = ~comp[0] & (|ring_nx[0]);
  assign idle    = (ring_nx == ring_q);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ring_q   <= RING_INIT;
      wave_cnt <= '0;
      data_val <= '0;
      wd_cnt   <= '0;
      stuck    <= 1'b0;
    end else if (en) begin
      ring_q <= ring_nx;
      if (arrival) begin
        if (wave_cnt != CNT_MAX) wave_cnt <= wave_cnt + 1'b1;
        data_val <= ring_nx[0];
      end
      if (!idle) begin
        wd_cnt <= '0;
      end else if (wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (idle && (wd_cnt >= WDOG_LAST)) stuck <= 1'b1;
    end
  end

`ifdef MR_RING_PERIOD_EN
  logic [CW-1:0] cyc_cnt;
  logic          seen;

  // The first arrival only starts the measurement; period shows from the second.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cyc_cnt <= '0;
      seen    <= 1'b0;
      period  <= '0;
    end else if (en) begin
      if (arrival) begin
        cyc_cnt <= '0;
        seen    <= 1'b1;
        if (seen) period <= (cyc_cnt == CNT_MAX) ? CNT_MAX : cyc_cnt + 1'b1;
      end else if (cyc_cnt != CNT_MAX) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_mr_ring.sv
// Bench for mr_ring: table-driven default-parameter sequences, corner sequences,
// a modelled random run, and a 4-rail/6-stage instance checked by properties.
module tb_mr_ring;

`ifdef MR_RING_PERIOD_EN
  localparam bit PERIOD_ON = 1'b1;
`else
  localparam bit PERIOD_ON = 1'b0;
`endif
  localparam int ROT  = 1;
  localparam int WDOG = 16;

  logic        clk = 1'b0;
  logic        init_n;
  logic        en;
  logic [3:0]  hold;
  logic [11:0] ring;
  logic [3:0]  comp;
  logic [15:0] wave_cnt;
  logic [2:0]  data_val;
  logic [15:0] period;
  logic        stuck;

  logic [23:0] ring2;
  logic [5:0]  comp2;
  logic [15:0] wave2;
  logic [3:0]  dv2;
  logic [15:0] per2;
  logic        stuck2;

  always #5 clk = ~clk;

  mr_ring #(.RAILS(3), .STAGES(4), .ROT(1), .DSTAGE(3), .DINIT(0), .CW(16), .WDOG(WDOG)) dut (
    .clk(clk), .init_n(init_n), .en(en), .hold(hold), .ring(ring), .comp(comp),
    .wave_cnt(wave_cnt), .data_val(data_val), .period(period), .stuck(stuck));

  mr_ring #(.RAILS(4), .STAGES(6), .ROT(1), .DSTAGE(5), .DINIT(0), .CW(16), .WDOG(WDOG)) dut2 (
    .clk(clk), .init_n(init_n), .en(1'b1), .hold(6'b000000), .ring(ring2), .comp(comp2),
    .wave_cnt(wave2), .data_val(dv2), .period(per2), .stuck(stuck2));

  typedef struct {
    logic [11:0] ring;
    logic [15:0] wave;
    logic [2:0]  dv;
    logic [15:0] per;
    logic        stuck;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] hold;
    exp_t       x;
  } vec_t;

  vec_t vec [10];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [2:0]  m_ring [4];
  logic [15:0] m_wave, m_per, m_cnt, m_wd;
  logic [2:0]  m_dv;
  logic        m_seen, m_stuck;

  int          narr, since, bad2;
  logic [15:0] prev_w, exp_per2;
  logic [3:0]  codes [4];
  logic [15:0] p4;

  function automatic exp_t mk(logic [11:0] r, logic [15:0] w, logic [2:0] d, logic [15:0] p, logic s);
    exp_t e;
    e.ring = r; e.wave = w; e.dv = d; e.per = p; e.stuck = s;
    return e;
  endfunction

  function automatic logic [3:0] comp_of(logic [11:0] r);
    logic [3:0] c;
    for (int s = 0; s < 4; s++) c[s] = |r[s*3 +: 3];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_exp(input string name, input exp_t e);
    logic bad;
    n_checks++;
    bad = (ring !== e.ring) || (comp !== comp_of(e.ring)) || (wave_cnt !== e.wave) ||
          (data_val !== e.dv) || (period !== e.per) || (stuck !== e.stuck);
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got ring=%b comp=%b wave=%0d dv=%b per=%0d stuck=%b, need ring=%b comp=%b wave=%0d dv=%b per=%0d stuck=%b",
               name, ring, comp, wave_cnt, data_val, period, stuck,
               e.ring, comp_of(e.ring), e.wave, e.dv, e.per, e.stuck);
    end
  endtask

  task automatic run_step(input string name, input logic e, input logic [3:0] h, input exp_t x);
    en   = e;
    hold = h;
    exp_q.push_back(x);
    tick();
    check_exp(name, exp_q.pop_front());
  endtask

  task automatic run_vec(input int i, input string tag);
    run_step($sformatf("%s_t%0d", tag, i), vec[i].en, vec[i].hold, vec[i].x);
  endtask

  // Asynchronous init pulse mid-cycle; state must be visible before any edge.
  task automatic start(input string tag);
    en     = 1'b1;
    hold   = 4'h0;
    init_n = 1'b1;
    #1;
    init_n = 1'b0;
    #1;
    check_exp({tag, "_init"}, vec[0].x);
    init_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_ring[s] = 3'b000;
    m_ring[3] = 3'b001;
    m_wave = '0; m_per = '0; m_cnt = '0; m_wd = '0;
    m_dv = '0; m_seen = 1'b0; m_stuck = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] h);
    logic [2:0] nxt [4];
    logic [2:0] src;
    logic       go, arr, moved;
    if (!e) return;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        for (int r = 0; r < 3; r++) src[r] = m_ring[3][(r + ROT) % 3];
      end else begin
        src = m_ring[(s + 3) % 4];
      end
      go = (m_ring[(s + 1) % 4] == 3'b000);
      for (int r = 0; r < 3; r++) begin
        if (h[s]) nxt[s][r] = m_ring[s][r];
        else case ({src[r], go})
          2'b11:   nxt[s][r] = 1'b1;
          2'b00:   nxt[s][r] = 1'b0;
          default: nxt[s][r] = m_ring[s][r];
        endcase
      end
    end
    arr   = (m_ring[0] == 3'b000) && (nxt[0] != 3'b000);
    moved = 1'b0;
    for (int s = 0; s < 4; s++) if (nxt[s] != m_ring[s]) moved = 1'b1;
    if (moved) m_wd = '0;
    else begin
      if (m_wd != 16'hFFFF) m_wd++;
      if (m_wd >= WDOG) m_stuck = 1'b1;
    end
    if (arr) begin
      if (m_wave != 16'hFFFF) m_wave++;
      m_dv = nxt[0];
    end
    if (PERIOD_ON) begin
      if (arr) begin
        if (m_seen) m_per = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
        m_seen = 1'b1;
        m_cnt  = '0;
      end else if (m_cnt != 16'hFFFF) m_cnt++;
    end
    for (int s = 0; s < 4; s++) m_ring[s] = nxt[s];
  endtask

  function automatic exp_t model_exp();
    return mk({m_ring[3], m_ring[2], m_ring[1], m_ring[0]}, m_wave, m_dv, m_per, m_stuck);
  endfunction

  initial begin
    #1000000;
    $display("FAIL tb_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    p4 = PERIOD_ON ? 16'd4 : 16'd0;
    codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010; codes[3] = 4'b0001;
    vec[0] = '{1'b1, 4'h0, mk(12'b001_000_000_000, 16'd0, 3'b000, 16'd0, 1'b0)};
    vec[1] = '{1'b1, 4'h0, mk(12'b001_000_000_100, 16'd1, 3'b100, 16'd0, 1'b0)};
    vec[2] = '{1'b1, 4'h0, mk(12'b000_000_100_100, 16'd1, 3'b100, 16'd0, 1'b0)};
    vec[3] = '{1'b1, 4'h0, mk(12'b000_100_100_000, 16'd1, 3'b100, 16'd0, 1'b0)};
    vec[4] = '{1'b1, 4'h0, mk(12'b100_100_000_000, 16'd1, 3'b100, 16'd0, 1'b0)};
    vec[5] = '{1'b1, 4'h0, mk(12'b100_000_000_010, 16'd2, 3'b010, p4, 1'b0)};
    vec[6] = '{1'b1, 4'h0, mk(12'b000_000_010_010, 16'd2, 3'b010, p4, 1'b0)};
    vec[7] = '{1'b1, 4'h0, mk(12'b000_010_010_000, 16'd2, 3'b010, p4, 1'b0)};
    vec[8] = '{1'b1, 4'h0, mk(12'b010_010_000_000, 16'd2, 3'b010, p4, 1'b0)};
    vec[9] = '{1'b1, 4'h0, mk(12'b010_000_000_001, 16'd3, 3'b001, p4, 1'b0)};

    init_n = 1'b1;
    en     = 1'b0;
    hold   = 4'h0;
    tick();

    // Free run from init.
    start("free");
    for (int i = 1; i < 10; i++) run_vec(i, "free");

    // Enable gap at t3: everything frozen, then the sequence resumes.
    start("gap");
    for (int i = 1; i <= 3; i++) run_vec(i, "gap");
    for (int k = 0; k < 10; k++) run_step("gap_frozen", 1'b0, 4'h0, vec[3].x);
    for (int i = 4; i < 10; i++) run_vec(i, "gap");

    // Init asserted mid-run at t6, between clock edges.
    start("midinit");
    for (int i = 1; i <= 6; i++) run_vec(i, "midinit");
    #3;
    init_n = 1'b0;
    #1;
    check_exp("midinit_async", vec[0].x);
    tick();
    check_exp("midinit_held", vec[0].x);
    #1;
    init_n = 1'b1;
    for (int i = 1; i < 10; i++) run_vec(i, "restart");

    // Stage 2 held from t2: ring stalls, watchdog trips after 16 idle cycles.
    start("hold");
    run_vec(1, "hold");
    for (int k = 2; k <= 19; k++)
      run_step($sformatf("hold_t%0d", k), 1'b1, 4'b0100,
               mk((k == 2) ? 12'b000_000_100_100 : 12'b000_000_100_000,
                  16'd1, 3'b100, 16'd0, (k >= 19)));
    run_step("hold_rel_t20", 1'b1, 4'h0, mk(12'b000_100_100_000, 16'd1, 3'b100, 16'd0, 1'b1));
    run_step("hold_rel_t21", 1'b1, 4'h0, mk(12'b100_100_000_000, 16'd1, 3'b100, 16'd0, 1'b1));
    run_step("hold_rel_t22", 1'b1, 4'h0,
             mk(12'b100_000_000_010, 16'd2, 3'b010, PERIOD_ON ? 16'd21 : 16'd0, 1'b1));

    // Random enables and holds against the reference model.
    start("rand");
    model_reset();
    for (int i = 0; i < 300; i++) begin
      logic       e;
      logic [3:0] h;
      e = ($urandom_range(0, 9) < 8);
      for (int b = 0; b < 4; b++) h[b] = ($urandom_range(0, 9) == 0);
      if (i >= 150 && i < 185) h = 4'b0010;
      model_step(e, h);
      run_step($sformatf("rand_%0d", i), e, h, model_exp());
    end

    // 4-rail, 6-stage instance: one-hot stages and rotating data codes.
    start("wide");
    en = 1'b1;
    hold = 4'h0;
    narr = 0;
    since = 0;
    prev_w = '0;
    for (int c = 0; c < 200 && narr < 5; c++) begin
      tick();
      since++;
      bad2 = 0;
      for (int s = 0; s < 6; s++) begin
        if (comp2[s] !== (|ring2[s*4 +: 4])) bad2++;
        if (comp2[s] && ($countones(ring2[s*4 +: 4]) != 1)) bad2++;
      end
      n_checks++;
      if (bad2 != 0) begin
        n_fail++;
        $display("FAIL wide_onehot: got ring=%b comp=%b, need one rail per completed stage", ring2, comp2);
      end
      if (wave2 != prev_w) begin
        narr++;
        exp_per2 = (PERIOD_ON && narr >= 2) ? 16'(since) : 16'd0;
        n_checks++;
        if (dv2 !== codes[(narr - 1) % 4] || per2 !== exp_per2 || wave2 !== 16'(narr) || stuck2 !== 1'b0) begin
          n_fail++;
          $display("FAIL wide_arrival%0d: got dv=%b per=%0d wave=%0d stuck=%b, need dv=%b per=%0d wave=%0d stuck=0",
                   narr, dv2, per2, wave2, stuck2, codes[(narr - 1) % 4], exp_per2, narr);
        end
        since  = 0;
        prev_w = wave2;
      end
    end
    n_checks++;
    if (narr < 5) begin
      n_fail++;
      $display("FAIL wide_timeout: got %0d arrivals, need 5 within 200 cycles", narr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
